// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer
// Description : Fetch/decode/sequence stage in front of the dual-read
//               register file. Accepts 32-bit instruction words over a
//               valid/ready link. Drives the opcode bus and the register
//               addresses. Sequences RAM transfers and issues the register
//               write strobe, with the write data taken from the ALU result
//               or from RAM read data.
//               Optional feature macro: RAM_TIMEOUT_EN enables an abort of
//               RAM transfers whose ack does not arrive in time.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_sequencer #(
   parameter int DATA_WIDTH     = 16,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  instr_valid,
   output logic                  instr_ready,
   input  logic [31:0]           instr_data,
   output logic [15:0]           opcode,
   output logic [3:0]            addr_1,
   output logic [3:0]            addr_2,
   output logic [3:0]            addr_3,
   input  logic [DATA_WIDTH-1:0] alu_result,
   output logic                  ram_req,
   input  logic                  ram_ack,
   input  logic [DATA_WIDTH-1:0] ram_rdata,
   output logic [DATA_WIDTH-1:0] write_data,
   output logic                  write_enable,
   output logic                  halted,
   output logic                  illegal_op,
   output logic                  timeout_err,
   output logic [CNT_WIDTH-1:0]  instr_count
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_EXEC     = 3'd1,
      S_WAIT_RAM = 3'd2,
      S_WB       = 3'd3,
      S_HALT     = 3'd4
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nx;

   logic [15:0]             r_opcode;
   logic [3:0]              r_addr_1;
   logic [3:0]              r_addr_2;
   logic [3:0]              r_addr_3;
   logic [DATA_WIDTH-1:0]   r_write_data;
   logic                    r_ram_req;
   logic                    r_illegal_op;
   logic [CNT_WIDTH-1:0]    r_instr_count;

   logic                    w_accept;
   logic                    w_retire;
   logic                    w_set_illegal;
   logic                    w_load_alu;
   logic                    w_load_ram;
   logic                    w_to_hit;

   logic                    w_is_alu;
   logic                    w_is_rd_ram;
   logic                    w_is_wr_ram;
   logic                    w_is_read;
   logic                    w_is_halt;
   logic                    w_is_nop;

   // Reserved instruction bits carry no meaning in this stage.
   logic                    w_unused_rsvd;
   assign w_unused_rsvd = ^instr_data[15:12];

   // Opcode classes, always decoded from the registered opcode.
   assign w_is_alu    = (r_opcode[15:12] == 4'h1);
   assign w_is_rd_ram = (r_opcode[15:8] == 8'h92);
   assign w_is_wr_ram = (r_opcode[15:8] == 8'h91);
   assign w_is_read   = (r_opcode[15:8] == 8'h22);
   assign w_is_halt   = (r_opcode == 16'hFF00);
   assign w_is_nop    = (r_opcode == 16'h0000);

   assign instr_ready = (r_state == S_IDLE);
   assign w_accept    = instr_valid && instr_ready;

   // State register; reset overrides any transfer in flight.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   // Next-state logic and the per-cycle datapath strobes.
   always_comb begin
      w_state_nx    = r_state;
      w_retire      = 1'b0;
      w_set_illegal = 1'b0;
      w_load_alu    = 1'b0;
      w_load_ram    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_nx = S_EXEC;
            end
         end
         S_EXEC: begin
            if (w_is_alu) begin
               w_load_alu = 1'b1;
               w_state_nx = S_WB;
            end else if (w_is_rd_ram || w_is_wr_ram) begin
               w_state_nx = S_WAIT_RAM;
            end else if (w_is_read || w_is_nop) begin
               w_retire   = 1'b1;
               w_state_nx = S_IDLE;
            end else if (w_is_halt) begin
               w_state_nx = S_HALT;
            end else begin
               w_set_illegal = 1'b1;
               w_retire      = 1'b1;
               w_state_nx    = S_IDLE;
            end
         end
         S_WAIT_RAM: begin
            // An ack in the same cycle as the timeout limit wins.
            if (ram_ack) begin
               if (w_is_rd_ram) begin
                  w_load_ram = 1'b1;
                  w_state_nx = S_WB;
               end else begin
                  w_retire   = 1'b1;
                  w_state_nx = S_IDLE;
               end
            end else if (w_to_hit) begin
               w_state_nx = S_IDLE;
            end
         end
         S_WB: begin
            w_retire   = 1'b1;
            w_state_nx = S_IDLE;
         end
         S_HALT: begin
            w_state_nx = S_HALT;
         end
         default: begin
            w_state_nx = S_IDLE;
         end
      endcase
   end

   // Instruction fields, write data, RAM request, sticky flag and counter.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_opcode      <= 16'h0000;
         r_addr_1      <= 4'h0;
         r_addr_2      <= 4'h0;
         r_addr_3      <= 4'h0;
         r_write_data  <= '0;
         r_ram_req     <= 1'b0;
         r_illegal_op  <= 1'b0;
         r_instr_count <= '0;
      end else begin
         if (w_accept) begin
            r_opcode <= instr_data[31:16];
            r_addr_1 <= instr_data[11:8];
            r_addr_2 <= instr_data[7:4];
            r_addr_3 <= instr_data[3:0];
         end else if ((r_state != S_IDLE) && (w_state_nx == S_IDLE)) begin
            // Returning to IDLE puts zero on the opcode/address bus.
            r_opcode <= 16'h0000;
            r_addr_1 <= 4'h0;
            r_addr_2 <= 4'h0;
            r_addr_3 <= 4'h0;
         end
         if (w_load_alu) begin
            r_write_data <= alu_result;
         end else if (w_load_ram) begin
            r_write_data <= ram_rdata;
         end
         // Request is high for exactly the cycles spent in WAIT_RAM.
         r_ram_req <= (w_state_nx == S_WAIT_RAM);
         if (w_set_illegal) begin
            r_illegal_op <= 1'b1;
         end
         if (w_retire) begin
            r_instr_count <= r_instr_count + 1'b1;
         end
      end
   end

`ifdef RAM_TIMEOUT_EN
   localparam int c_TO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);

   logic [c_TO_W-1:0] r_to_cnt;
   logic              r_timeout_err;

   assign w_to_hit    = (r_to_cnt == c_TO_LAST);
   assign timeout_err = r_timeout_err;

   // Counts WAIT_RAM cycles without ack; parked at zero elsewhere.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_to_cnt      <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         if (r_state != S_WAIT_RAM) begin
            r_to_cnt <= '0;
         end else if (!ram_ack && !w_to_hit) begin
            r_to_cnt <= r_to_cnt + 1'b1;
         end
         if ((r_state == S_WAIT_RAM) && !ram_ack && w_to_hit) begin
            r_timeout_err <= 1'b1;
         end
      end
   end
`else
   localparam int c_unused_timeout = TIMEOUT_CYCLES;

   assign w_to_hit    = 1'b0;
   assign timeout_err = 1'b0;
`endif

   assign opcode       = r_opcode;
   assign addr_1       = r_addr_1;
   assign addr_2       = r_addr_2;
   assign addr_3       = r_addr_3;
   assign write_data   = r_write_data;
   assign write_enable = (r_state == S_WB);
   assign ram_req      = r_ram_req;
   assign halted       = (r_state == S_HALT);
   assign illegal_op   = r_illegal_op;
   assign instr_count  = r_instr_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_sequencer
// Description : Directed self-checking bench for instr_sequencer. Runs with a
//               4-bit retire counter so wrap-around is reachable, and an
//               8-cycle RAM timeout when RAM_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;

   localparam int c_DW = 16;
   localparam int c_CW = 4;

   logic            clk;
   logic            reset_n;
   logic            instr_valid;
   logic            instr_ready;
   logic [31:0]     instr_data;
   logic [15:0]     opcode;
   logic [3:0]      addr_1;
   logic [3:0]      addr_2;
   logic [3:0]      addr_3;
   logic [c_DW-1:0] alu_result;
   logic            ram_req;
   logic            ram_ack;
   logic [c_DW-1:0] ram_rdata;
   logic [c_DW-1:0] write_data;
   logic            write_enable;
   logic            halted;
   logic            illegal_op;
   logic            timeout_err;
   logic [c_CW-1:0] instr_count;

   int r_total = 0;
   int r_bad   = 0;
   int r_we_cnt = 0;

   instr_sequencer #(
      .DATA_WIDTH     (c_DW),
      .TIMEOUT_CYCLES (8),
      .CNT_WIDTH      (c_CW)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .instr_data   (instr_data),
      .opcode       (opcode),
      .addr_1       (addr_1),
      .addr_2       (addr_2),
      .addr_3       (addr_3),
      .alu_result   (alu_result),
      .ram_req      (ram_req),
      .ram_ack      (ram_ack),
      .ram_rdata    (ram_rdata),
      .write_data   (write_data),
      .write_enable (write_enable),
      .halted       (halted),
      .illegal_op   (illegal_op),
      .timeout_err  (timeout_err),
      .instr_count  (instr_count)
   );

   // 100 MHz clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts write strobes seen at active edges.
   always @(posedge clk) begin
      if (write_enable) r_we_cnt = r_we_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      r_total = r_total + 1;
      if (got !== exp) begin
         r_bad = r_bad + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one instruction for a single accept edge; returns in EXEC.
   task automatic send(input logic [31:0] word);
      instr_valid = 1'b1;
      instr_data  = word;
      tick();
      instr_valid = 1'b0;
   endtask

   int n_req;
   int we_base;

   initial begin
      reset_n     = 1'b0;
      instr_valid = 1'b0;
      instr_data  = 32'h0;
      alu_result  = 16'h0;
      ram_ack     = 1'b0;
      ram_rdata   = 16'h0;
      tick();
      tick();
      reset_n = 1'b1;

      // Reset state
      check("rst_ready",   instr_ready, 1);
      check("rst_opcode",  opcode, 16'h0000);
      check("rst_ram_req", ram_req, 0);
      check("rst_we",      write_enable, 0);
      check("rst_halted",  halted, 0);
      check("rst_illegal", illegal_op, 0);
      check("rst_timeout", timeout_err, 0);
      check("rst_count",   instr_count, 0);

      // ALU: write strobe one cycle, two cycles after the accept edge
      alu_result = 16'hBEEF;
      we_base    = r_we_cnt;
      send(32'h1000_0123);
      check("alu_exec_opcode", opcode, 16'h1000);
      check("alu_exec_addrs",  {addr_1, addr_2, addr_3}, 12'h123);
      check("alu_exec_we",     write_enable, 0);
      check("alu_exec_ready",  instr_ready, 0);
      tick();
      check("alu_wb_we",    write_enable, 1);
      check("alu_wb_data",  write_data, 16'hBEEF);
      check("alu_wb_addr3", addr_3, 4'h3);
      tick();
      check("alu_idle_we",     write_enable, 0);
      check("alu_idle_ready",  instr_ready, 1);
      check("alu_idle_opcode", opcode, 16'h0000);
      check("alu_count",       instr_count, 1);
      check("alu_we_pulses",   r_we_cnt - we_base, 1);

      // READ_RAM: four cycles without ack, ack on the fifth
      ram_rdata = 16'h1234;
      send(32'h9200_0005);
      check("rr_exec_req", ram_req, 0);
      tick();
      n_req = 0;
      for (int i = 0; i < 5; i++) begin
         if (ram_req) n_req++;
         check("rr_wait_we", write_enable, 0);
         ram_ack = (i == 4);
         tick();
      end
      ram_ack = 1'b0;
      check("rr_req_cycles", n_req, 5);
      check("rr_wb_req",     ram_req, 0);
      check("rr_wb_we",      write_enable, 1);
      check("rr_wb_data",    write_data, 16'h1234);
      check("rr_wb_addr3",   addr_3, 4'h5);
      tick();
      check("rr_count", instr_count, 2);

      // WRITE_RAM then an undefined opcode: neither writes the register file
      we_base = r_we_cnt;
      send(32'h9100_0007);
      tick();
      check("wr_wait_req", ram_req, 1);
      tick();
      ram_ack = 1'b1;
      tick();
      ram_ack = 1'b0;
      check("wr_done_req",   ram_req, 0);
      check("wr_done_ready", instr_ready, 1);
      check("wr_count",      instr_count, 3);
      // ack outside WAIT_RAM must not disturb anything
      ram_ack = 1'b1;
      send(32'h7700_0000);
      ram_ack = 1'b0;
      tick();
      check("ill_flag",   illegal_op, 1);
      check("ill_count",  instr_count, 4);
      check("ill_ready",  instr_ready, 1);
      check("wr_ill_no_we", r_we_cnt - we_base, 0);

      // READ: single-cycle retire
      send(32'h2200_0012);
      check("rd_exec_opcode", opcode, 16'h2200);
      tick();
      check("rd_count", instr_count, 5);
      check("rd_no_we", r_we_cnt - we_base, 0);

      // NOPs drive the 4-bit counter through its wrap
      for (int i = 0; i < 10; i++) begin
         send(32'h0000_0000);
         tick();
      end
      check("nop_count_max", instr_count, 4'hF);
      send(32'h0000_0000);
      tick();
      check("nop_count_wrap", instr_count, 4'h0);
      check("nop_sticky_ill", illegal_op, 1);

`ifdef RAM_TIMEOUT_EN
      // No ack: abort after 8 cycles in WAIT_RAM, no retire, no write
      we_base = r_we_cnt;
      send(32'h9200_0001);
      tick();
      for (int i = 0; i < 7; i++) tick();
      check("to_last_wait_req", ram_req, 1);
      check("to_not_yet",       timeout_err, 0);
      tick();
      check("to_err",   timeout_err, 1);
      check("to_req",   ram_req, 0);
      check("to_ready", instr_ready, 1);
      check("to_count", instr_count, 0);
      check("to_no_we", r_we_cnt - we_base, 0);
`else
      // No timeout: WAIT_RAM holds the request indefinitely
      ram_rdata = 16'h0F0F;
      send(32'h9200_0001);
      tick();
      for (int i = 0; i < 20; i++) tick();
      check("wait_req_held", ram_req, 1);
      check("wait_no_to",    timeout_err, 0);
      ram_ack = 1'b1;
      tick();
      ram_ack = 1'b0;
      check("wait_wb_data", write_data, 16'h0F0F);
      tick();
      check("wait_count", instr_count, 1);
`endif

      // Reset in the middle of a RAM read, with an ack arriving at the reset edge
      send(32'h9200_0003);
      tick();
      check("rstw_req_before", ram_req, 1);
      we_base   = r_we_cnt;
      reset_n   = 1'b0;
      ram_ack   = 1'b1;
      tick();
      reset_n   = 1'b1;
      ram_ack   = 1'b0;
      check("rstw_req",    ram_req, 0);
      check("rstw_opcode", opcode, 16'h0000);
      check("rstw_ready",  instr_ready, 1);
      check("rstw_count",  instr_count, 0);
      check("rstw_illegal", illegal_op, 0);
      tick();
      check("rstw_no_we", r_we_cnt - we_base, 0);

      // HALT with instr_valid held high
      instr_valid = 1'b1;
      instr_data  = 32'hFF00_0000;
      tick();
      tick();
      check("halt_flag",  halted, 1);
      check("halt_ready", instr_ready, 0);
      for (int i = 0; i < 5; i++) tick();
      check("halt_stays",  halted, 1);
      check("halt_opcode", opcode, 16'hFF00);
      check("halt_count",  instr_count, 0);
      reset_n     = 1'b0;
      instr_valid = 1'b0;
      tick();
      reset_n = 1'b1;
      check("halt_rst_flag",  halted, 0);
      check("halt_rst_ready", instr_ready, 1);

      $display("test done: total=%0d bad=%0d", r_total, r_bad);
      $finish;
   end

endmodule
`default_nettype wire
